// File: rtl/axilgpio_irqsvc_if.sv
// axilgpio_irqsvc_if
//   AXI4-Lite bus bundle between the interrupt-service engine (master) and
//   the GPIO peripheral register file (slave).
//   Write address : M_AXI_AWVALID / M_AXI_AWREADY / M_AXI_AWADDR[4:0]
//   Write data    : M_AXI_WVALID / M_AXI_WREADY / M_AXI_WDATA[31:0] / M_AXI_WSTRB[3:0]
//   Write response: M_AXI_BVALID / M_AXI_BREADY / M_AXI_BRESP[1:0]
//   Read address  : M_AXI_ARVALID / M_AXI_ARREADY / M_AXI_ARADDR[4:0]
//   Read data     : M_AXI_RVALID / M_AXI_RREADY / M_AXI_RDATA[31:0] / M_AXI_RRESP[1:0]
`timescale 1ns/1ps
interface axilgpio_irqsvc_if;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [4:0]  M_AXI_AWADDR;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [4:0]  M_AXI_ARADDR;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;

  modport master (
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
           M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
           M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

  modport slave (
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
           M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
           M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );
endinterface

// File: rtl/axilgpio_irqsvc.sv
// axilgpio_irqsvc
//   Services the level interrupt of an AXI-Lite GPIO block: reads ISR (0x1C),
//   reads IN (0x10), clears the serviced sources in CHANGED (0x14, W1C) and
//   hands a {src, lvl} record to a valid/ready consumer.
//   Optional macro AXILGPIO_IRQSVC_INIT_EN: after reset, writes MASK_INIT to
//   MASK (0x18) once before servicing interrupts.
// Ports
//   M_AXI_ACLK      clock, rising edge
//   M_AXI_ARESET    asynchronous active-high reset
//   i_int           level interrupt from the GPIO peripheral
//   m_axi           AXI-Lite master bus (axilgpio_irqsvc_if.master)
//   o_evt_valid/i_evt_ready, o_evt_src[NIN], o_evt_lvl[NIN]  event record
//   o_err           sticky AXI error flag (RRESP/BRESP non-OKAY)
//   o_busy          high whenever the FSM is not in IDLE
`timescale 1ns/1ps
module axilgpio_irqsvc #(
  parameter int             NIN       = 5,
  parameter logic [NIN-1:0] MASK_INIT = {NIN{1'b1}}
) (
  input  logic                     M_AXI_ACLK,
  input  logic                     M_AXI_ARESET,
  input  logic                     i_int,
  axilgpio_irqsvc_if.master        m_axi,
  output logic                     o_evt_valid,
  input  logic                     i_evt_ready,
  output logic [NIN-1:0]           o_evt_src,
  output logic [NIN-1:0]           o_evt_lvl,
  output logic                     o_err,
  output logic                     o_busy
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_RD_ISR = 3'd2;
  localparam logic [2:0] S_RD_IN  = 3'd3;
  localparam logic [2:0] S_WR_CLR = 3'd4;
  localparam logic [2:0] S_EVT    = 3'd5;

  localparam logic [4:0] ADDR_IN   = 5'h10;
  localparam logic [4:0] ADDR_CHG  = 5'h14;
  localparam logic [4:0] ADDR_MASK = 5'h18;
  localparam logic [4:0] ADDR_ISR  = 5'h1C;

  logic [2:0]     state;
  logic           start;     // request of the current state goes out next edge
  logic [NIN-1:0] src;
  logic [NIN-1:0] lvl;
  logic           arvalid;
  logic           rready;
  logic           awvalid;
  logic           wvalid;
  logic           bready;
`ifdef AXILGPIO_IRQSVC_INIT_EN
  logic           boot;      // first cycle after reset release diverts IDLE into INIT
`endif

  logic rd_done, rd_err, wr_done, wr_err;
  assign rd_done = m_axi.M_AXI_RVALID && rready;
  assign rd_err  = (m_axi.M_AXI_RRESP != 2'b00);
  assign wr_done = m_axi.M_AXI_BVALID && bready;
  assign wr_err  = (m_axi.M_AXI_BRESP != 2'b00);

  // Address/data are decoded from the state, so they hold for the whole phase.
  assign m_axi.M_AXI_ARVALID = arvalid;
  assign m_axi.M_AXI_ARADDR  = (state == S_RD_ISR) ? ADDR_ISR : ADDR_IN;
  assign m_axi.M_AXI_RREADY  = rready;
  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_AWADDR  = (state == S_WR_CLR) ? ADDR_CHG : ADDR_MASK;
  assign m_axi.M_AXI_WVALID  = wvalid;
  assign m_axi.M_AXI_WDATA   = (state == S_WR_CLR) ? 32'(src) : 32'(MASK_INIT);
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_BREADY  = bready;

  assign o_evt_src = src;
  assign o_evt_lvl = lvl;
  assign o_busy    = (state != S_IDLE);

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state       <= S_IDLE;
      start       <= 1'b0;
      src         <= '0;
      lvl         <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      o_evt_valid <= 1'b0;
      o_err       <= 1'b0;
`ifdef AXILGPIO_IRQSVC_INIT_EN
      boot        <= 1'b1;
`endif
    end else begin
      start <= 1'b0;
      if (start) begin
        if (state == S_RD_ISR || state == S_RD_IN) begin
          arvalid <= 1'b1;
          rready  <= 1'b1;
        end else begin
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          bready  <= 1'b1;
        end
      end
      // Each VALID drops on its own READY; READY drops once the response lands.
      if (arvalid && m_axi.M_AXI_ARREADY) arvalid <= 1'b0;
      if (awvalid && m_axi.M_AXI_AWREADY) awvalid <= 1'b0;
      if (wvalid && m_axi.M_AXI_WREADY)   wvalid  <= 1'b0;
      if (rd_done)                        rready  <= 1'b0;
      if (wr_done)                        bready  <= 1'b0;

      case (state)
        S_IDLE: begin
`ifdef AXILGPIO_IRQSVC_INIT_EN
          if (boot) begin
            boot  <= 1'b0;
            state <= S_INIT;
            start <= 1'b1;
          end else
`endif
          if (i_int) begin
            state <= S_RD_ISR;
            start <= 1'b1;
          end
        end
        S_INIT: begin
          if (wr_done) begin
            if (wr_err) o_err <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_RD_ISR: begin
          if (rd_done) begin
            if (rd_err) begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end else if (m_axi.M_AXI_RDATA[NIN-1:0] == '0) begin
              state <= S_IDLE;  // spurious: nothing pending
            end else begin
              src   <= m_axi.M_AXI_RDATA[NIN-1:0];
              state <= S_RD_IN;
              start <= 1'b1;
            end
          end
        end
        S_RD_IN: begin
          if (rd_done) begin
            if (rd_err) begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end else begin
              lvl   <= m_axi.M_AXI_RDATA[NIN-1:0];
              state <= S_WR_CLR;
              start <= 1'b1;
            end
          end
        end
        S_WR_CLR: begin
          if (wr_done) begin
            if (wr_err) begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end else begin
              o_evt_valid <= 1'b1;
              state       <= S_EVT;
            end
          end
        end
        S_EVT: begin
          if (i_evt_ready) begin
            o_evt_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilgpio_irqsvc.sv
`timescale 1ns/1ps
module tb_axilgpio_irqsvc;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic       clk;
  logic       rst;
  logic       i_int;
  logic       i_evt_ready;
  logic       o_evt_valid;
  logic [4:0] o_evt_src;
  logic [4:0] o_evt_lvl;
  logic       o_err;
  logic       o_busy;

  axilgpio_irqsvc_if bus();

  axilgpio_irqsvc #(.NIN(5), .MASK_INIT(5'h1F)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .i_int        (i_int),
    .m_axi        (bus),
    .o_evt_valid  (o_evt_valid),
    .i_evt_ready  (i_evt_ready),
    .o_evt_src    (o_evt_src),
    .o_evt_lvl    (o_evt_lvl),
    .o_err        (o_err),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues and slave configuration
  wr_t         exp_wr[$];
  logic [9:0]  exp_evt[$];
  int          wr_count = 0;
  int          evt_count = 0;
  logic [31:0] isr_val, in_val;
  logic [1:0]  isr_resp;
  int          aw_delay_cfg;

  // AXI-Lite slave model and output monitor; acts 2ns after the falling edge
  logic       ar_fire_p, r_fire_p, b_fire_p, b_next, aw_got, w_got, aw_pend;
  logic [4:0] r_addr, wr_addr, aw_hold_a;
  logic [31:0] wr_data, aw_hold_d;
  int         aw_wait;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = '0;
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = '0;
      ar_fire_p = 0; r_fire_p = 0; b_fire_p = 0; b_next = 0; aw_got = 0; w_got = 0; aw_pend = 0;
      aw_wait = 0;
    end else begin
      if (r_fire_p) bus.M_AXI_RVALID = 1'b0;
      if (b_fire_p) bus.M_AXI_BVALID = 1'b0;
      if (ar_fire_p) begin
        bus.M_AXI_RVALID = 1'b1;
        bus.M_AXI_RDATA  = (r_addr == 5'h1C) ? isr_val : in_val;
        bus.M_AXI_RRESP  = (r_addr == 5'h1C) ? isr_resp : 2'b00;
      end
      if (b_next) begin
        bus.M_AXI_BVALID = 1'b1;
        bus.M_AXI_BRESP  = 2'b00;
        b_next = 0;
      end
      bus.M_AXI_ARREADY = 1'b1;
      bus.M_AXI_WREADY  = 1'b1;
      if (bus.M_AXI_AWVALID && aw_wait < aw_delay_cfg) begin
        bus.M_AXI_AWREADY = 1'b0;
        aw_wait++;
      end else begin
        bus.M_AXI_AWREADY = 1'b1;
      end
      // handshakes that complete on the coming rising edge
      ar_fire_p = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
      if (ar_fire_p) r_addr = bus.M_AXI_ARADDR;
      r_fire_p = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
      b_fire_p = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
      if (bus.M_AXI_AWVALID) begin
        if (aw_pend) begin
          chk("awaddr_stable", 32'(bus.M_AXI_AWADDR), 32'(aw_hold_a));
          chk("wdata_stable", bus.M_AXI_WDATA, aw_hold_d);
        end
        aw_pend   = !bus.M_AXI_AWREADY;
        aw_hold_a = bus.M_AXI_AWADDR;
        aw_hold_d = bus.M_AXI_WDATA;
      end
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        aw_got = 1; wr_addr = bus.M_AXI_AWADDR; aw_wait = 0;
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        w_got = 1; wr_data = bus.M_AXI_WDATA;
        chk("wstrb", 32'(bus.M_AXI_WSTRB), 32'h0000_000F);
      end
      if (aw_got && w_got) begin
        wr_t e;
        aw_got = 0; w_got = 0; b_next = 1; wr_count++;
        chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", wr_data, e.d);
        end
      end
      if (o_evt_valid && i_evt_ready) begin
        logic [9:0] ev;
        evt_count++;
        chk("evt_expected", 32'(exp_evt.size() != 0), 32'd1);
        if (exp_evt.size() != 0) begin
          ev = exp_evt.pop_front();
          chk("evt_src", 32'(o_evt_src), 32'(ev[9:5]));
          chk("evt_lvl", 32'(o_evt_lvl), 32'(ev[4:0]));
        end
      end
    end
  end

  task automatic wait_idle(input string tag, output logic saw);
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_busy) saw = 1'b1;
      else if (saw) break;
    end
    chk(tag, 32'(o_busy), 32'd0);
  endtask

  task automatic service(input logic [31:0] isr, input logic [31:0] inv, input int hold,
                         input int awd, input logic check_lat);
    int   lat;
    int   w0;
    logic saw;
    @(negedge clk);
    isr_val = isr; in_val = inv; isr_resp = 2'b00; aw_delay_cfg = awd;
    i_evt_ready = (hold == 0);
    w0 = wr_count;
    exp_wr.push_back('{5'h14, isr & 32'h0000_001F});
    exp_evt.push_back({isr[4:0], inv[4:0]});
    i_int = 1'b1;
    lat = 0;
    while (!o_evt_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("evt_seen", 32'(o_evt_valid), 32'd1);
    if (check_lat) chk("latency", 32'(lat), 32'd10);
    chk("svc_wr_cnt", 32'(wr_count - w0), 32'd1);
    @(negedge clk);
    i_int = 1'b0;
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", 32'(o_evt_valid), 32'd1);
      chk("hold_src", 32'(o_evt_src), 32'(isr[4:0]));
      chk("hold_lvl", 32'(o_evt_lvl), 32'(inv[4:0]));
      @(negedge clk);
    end
    i_evt_ready = 1'b1;
    wait_idle("svc_idle", saw);
    aw_delay_cfg = 0;
  endtask

  task automatic pulse_int(input logic [31:0] isr, input logic [1:0] resp, input string tag);
    logic saw;
    int   w0, e0;
    @(negedge clk);
    isr_val = isr; isr_resp = resp;
    w0 = wr_count; e0 = evt_count;
    i_int = 1'b1;
    @(negedge clk);
    i_int = 1'b0;
    wait_idle(tag, saw);
    chk({tag, "_busy_seen"}, 32'(saw), 32'd1);
    chk({tag, "_no_wr"}, 32'(wr_count - w0), 32'd0);
    chk({tag, "_no_evt"}, 32'(evt_count - e0), 32'd0);
    isr_resp = 2'b00;
  endtask

  initial begin
    logic saw;
    int   e0;
    rst = 1'b1; i_int = 1'b0; i_evt_ready = 1'b1;
    isr_val = '0; in_val = '0; isr_resp = 2'b00; aw_delay_cfg = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({o_evt_valid, o_err, o_busy, bus.M_AXI_ARVALID, bus.M_AXI_RREADY,
                            bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY}), 32'd0);
`ifdef AXILGPIO_IRQSVC_INIT_EN
    exp_wr.push_back('{5'h18, 32'h0000_001F});
`endif
    @(negedge clk);
    rst = 1'b0;
    wait_idle("init_idle", saw);
`ifdef AXILGPIO_IRQSVC_INIT_EN
    chk("init_busy_seen", 32'(saw), 32'd1);
    chk("init_wr_cnt", 32'(wr_count), 32'd1);
`else
    chk("noinit_wr_cnt", 32'(wr_count), 32'd0);
`endif

    service(32'h0000_0005, 32'h0000_0015, 0, 0, 1'b1);
    service(32'hFFFF_FFE3, 32'h0000_0A1E, 0, 0, 1'b0);
    pulse_int(32'h0000_0000, 2'b00, "spurious");
    service(32'h0000_0005, 32'h0000_0015, 5, 3, 1'b0);

    pulse_int(32'h0000_0005, 2'b10, "rd_err");
    chk("err_set", 32'(o_err), 32'd1);
    service(32'h0000_0010, 32'h0000_0001, 0, 0, 1'b0);
    chk("err_sticky", 32'(o_err), 32'd1);

    // reset while the CHANGED write is waiting on AWREADY
    @(negedge clk);
    isr_val = 32'h3; in_val = 32'h7; aw_delay_cfg = 3; i_int = 1'b1;
    e0 = evt_count;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.M_AXI_AWVALID) break;
    end
    i_int = 1'b0;
    chk("rst_aw_seen", 32'(bus.M_AXI_AWVALID), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", 32'({o_evt_valid, o_busy, bus.M_AXI_ARVALID, bus.M_AXI_RREADY,
                               bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY}), 32'd0);
    chk("midrst_err_clr", 32'(o_err), 32'd0);
    repeat (2) @(negedge clk);
    aw_delay_cfg = 0;
`ifdef AXILGPIO_IRQSVC_INIT_EN
    exp_wr.push_back('{5'h18, 32'h0000_001F});
`endif
    rst = 1'b0;
    wait_idle("post_rst_idle", saw);
    chk("post_rst_no_evt", 32'(evt_count - e0), 32'd0);
    chk("wr_q_empty", 32'(exp_wr.size()), 32'd0);
    chk("evt_q_empty", 32'(exp_evt.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axilgpio_irqsvc.md
AXILGPIO_IRQSVC -- requirements
Module: axilgpio_irqsvc

Interface
REQ-001 SHALL have parameter NIN, default 5, number of GPIO inputs serviced (1..32).
REQ-002 SHALL have parameter MASK_INIT, default all-ones (NIN bits), interrupt mask value written at start-up.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 M_AXI_ACLK  input  1  sole clock, rising edge.
REQ-005 M_AXI_ARESET  input  1  asynchronous active-high reset.
REQ-006 i_int  input  1  level interrupt from GPIO peripheral.
REQ-007 M_AXI_AWVALID  output  1  write address valid.
REQ-008 M_AXI_AWREADY  input  1  write address accepted.
REQ-009 M_AXI_AWADDR  output  5  write byte address.
REQ-010 M_AXI_WVALID  output  1  write data valid.
REQ-011 M_AXI_WREADY  input  1  write data accepted.
REQ-012 M_AXI_WDATA  output  32  write data.
REQ-013 M_AXI_WSTRB  output  4  byte strobes, constant 4'hF.
REQ-014 M_AXI_BVALID  input  1  write response valid.
REQ-015 M_AXI_BREADY  output  1  write response ready.
REQ-016 M_AXI_BRESP  input  2  write response code.
REQ-017 M_AXI_ARVALID  output  1  read address valid.
REQ-018 M_AXI_ARREADY  input  1  read address accepted.
REQ-019 M_AXI_ARADDR  output  5  read byte address.
REQ-020 M_AXI_RVALID  input  1  read data valid.
REQ-021 M_AXI_RREADY  output  1  read data ready.
REQ-022 M_AXI_RDATA  input  32  read data.
REQ-023 M_AXI_RRESP  input  2  read response code.
REQ-024 o_evt_valid  output  1  serviced-event record valid.
REQ-025 i_evt_ready  input  1  consumer accepts record.
REQ-026 o_evt_src  output  NIN  captured interrupt-source bits.
REQ-027 o_evt_lvl  output  NIN  captured input levels.
REQ-028 o_err  output  1  sticky AXI error flag.
REQ-029 o_busy  output  1  high whenever FSM not in IDLE.

Function
REQ-030 Register map targeted: IN 0x10, CHANGED 0x14 (write-1-to-clear), MASK 0x18, ISR 0x1C.
REQ-031 FSM states: INIT, IDLE, RD_ISR, RD_IN, WR_CLR, EVT; one AXI transaction in flight at most.
REQ-032 IDLE: i_int sampled high -> RD_ISR next cycle; i_int ignored in all other states (level, re-sampled on IDLE return).
REQ-033 Read phase: ARVALID asserted with ARADDR stable until ARREADY; RREADY held high until RVALID; data captured on RVALID&&RREADY.
REQ-034 Write phase: AWVALID and WVALID asserted same cycle; each deasserted independently on its own ready; BREADY high until BVALID; phase done on BVALID&&BREADY.
REQ-035 VALID outputs SHALL never depend combinationally on any READY input.
REQ-036 RD_ISR: capture RDATA[NIN-1:0] into src; src zero -> IDLE (spurious, no event); else -> RD_IN.
REQ-037 RD_IN: capture RDATA[NIN-1:0] into lvl -> WR_CLR.
REQ-038 WR_CLR: write {zeros, src} to 0x14 -> EVT.
REQ-039 EVT: o_evt_valid high with src/lvl stable until i_evt_ready; transfer -> IDLE next cycle.
REQ-040 Any RRESP/BRESP != 2'b00: o_err set (sticky), sequence aborts to IDLE, no event.
REQ-041 Each state begins its AXI request the cycle after the previous phase completes; zero-wait slave: i_int to o_evt_valid 10 cycles.

Reset
REQ-042 Reset SHALL asynchronously clear all VALID/READY outputs, o_evt_*, o_err, o_busy, src, lvl; mid-transaction reset abandons the transaction.
REQ-043 Reset release SHALL enter INIT if AXILGPIO_IRQSVC_INIT_EN defined, else IDLE.

Configuration
REQ-044 Macro AXILGPIO_IRQSVC_INIT_EN defined: after reset, INIT writes MASK_INIT to 0x18 once, then IDLE; o_busy high during INIT; BRESP error sets o_err and still enters IDLE.
REQ-045 Macro undefined: INIT state absent, no mask write, IDLE directly after reset.

Verification
REQ-046 Init: INIT_EN, MASK_INIT=5'h1F -> single write 0x18=0x0000001F after reset, then o_busy=0.
REQ-047 Service: ISR reads 0x05, IN reads 0x15 -> write 0x14=0x05; o_evt_src=0x05, o_evt_lvl=0x15.
REQ-048 Spurious: i_int pulse, ISR reads 0 -> no write, no o_evt_valid, IDLE.
REQ-049 Backpressure: AWREADY 3 cycles after WREADY, i_evt_ready low 5 cycles -> AWADDR/WDATA/o_evt_* stable, single write.
REQ-050 Error: RRESP=2'b10 on ISR read -> o_err=1 until reset, no event; reset mid-WR_CLR -> all valids 0 immediately.
